// File: rtl/rx_conn_filter.sv
// Ingress connection filter: looks up beat 0 of each packet as a key, forwards hits tagged with the connection ID,
// drops misses and timed-out lookups. Build with RX_CONN_FILTER_MISS_PASS_EN to forward misses with tuser=all-ones.
module rx_conn_filter #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STALE_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tstrb,
    input  logic             s_axis_tlast,
    output logic             lkp_req_valid,
    input  logic             lkp_req_ready,
    output logic [63:0]      lkp_req_key,
    input  logic             lkp_resp_valid,
    output logic             lkp_resp_ready,
    input  logic             lkp_resp_hit,
    input  logic [31:0]      lkp_resp_id,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tstrb,
    output logic             m_axis_tlast,
    output logic [31:0]      m_axis_tuser,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FWD_HDR, S_FWD, S_DROP} state_t;

    localparam int                 TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST  = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [STALE_W-1:0] STALE_MAX = '1;
`ifdef RX_CONN_FILTER_MISS_PASS_EN
    localparam logic [31:0]        MISS_ID   = 32'hFFFF_FFFF;
`endif

    state_t             state_q, state_d;
    logic [63:0]        hdr_data_q, hdr_data_d;
    logic [7:0]         hdr_strb_q, hdr_strb_d;
    logic               hdr_last_q, hdr_last_d;
    logic [31:0]        id_q, id_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [STALE_W-1:0] stale_q, stale_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic   in_hs, resp_hs, stale_resp, live_resp, tmo_fire, lookup_fail;
    state_t miss_next;

    assign in_hs      = s_axis_tvalid && s_axis_tready;
    assign resp_hs    = lkp_resp_valid && lkp_resp_ready;
    assign stale_resp = resp_hs && (stale_q != '0);
    assign live_resp  = resp_hs && (stale_q == '0) && (state_q == S_WAIT);
    // A response of any kind in the same cycle suppresses the timeout.
    assign tmo_fire   = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !lkp_resp_valid &&
                        (tmo_q == TMO_LAST) && (stale_q != STALE_MAX);
    assign lookup_fail = (live_resp && !lkp_resp_hit) || tmo_fire;

`ifdef RX_CONN_FILTER_MISS_PASS_EN
    assign miss_next = S_FWD_HDR;
`else
    assign miss_next = hdr_last_q ? S_IDLE : S_DROP;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_hs) state_d = S_REQ;
            S_REQ:     if (lkp_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (live_resp && lkp_resp_hit) state_d = S_FWD_HDR;
                else if (lookup_fail)          state_d = miss_next;
            end
            S_FWD_HDR: if (m_axis_tready) state_d = hdr_last_q ? S_IDLE : S_FWD;
            S_FWD:     if (in_hs && s_axis_tlast) state_d = S_IDLE;
            S_DROP:    if (in_hs && s_axis_tlast) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready  = 1'b0;
        lkp_req_valid  = 1'b0;
        lkp_resp_ready = (state_q == S_WAIT) || (stale_q != '0);
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = hdr_data_q;
        m_axis_tstrb   = hdr_strb_q;
        m_axis_tlast   = hdr_last_q;
        case (state_q)
            S_IDLE:    s_axis_tready = 1'b1;
            S_REQ:     lkp_req_valid = 1'b1;
            S_FWD_HDR: m_axis_tvalid = 1'b1;
            S_FWD: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tstrb  = s_axis_tstrb;
                m_axis_tlast  = s_axis_tlast;
            end
            S_DROP:    s_axis_tready = 1'b1;
            default:   ;
        endcase
    end

    assign lkp_req_key  = hdr_data_q;
    assign m_axis_tuser = id_q;
    assign drop_count   = drop_q;
    assign busy         = (state_q != S_IDLE);

    always_comb begin
        hdr_data_d = hdr_data_q;
        hdr_strb_d = hdr_strb_q;
        hdr_last_d = hdr_last_q;
        id_d       = id_q;
        tmo_d      = tmo_q;
        stale_d    = stale_q;
        drop_d     = drop_q;
        if (state_q == S_IDLE && in_hs) begin
            hdr_data_d = s_axis_tdata;
            hdr_strb_d = s_axis_tstrb;
            hdr_last_d = s_axis_tlast;
        end
        if (live_resp && lkp_resp_hit) id_d = lkp_resp_id;
`ifdef RX_CONN_FILTER_MISS_PASS_EN
        if (lookup_fail) id_d = MISS_ID;
`endif
        // Counter parks at its terminal value so a saturated stale count defers the timeout.
        if (state_q == S_REQ && lkp_req_ready) tmo_d = '0;
        else if (state_q == S_WAIT && tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
        if (stale_resp)    stale_d = stale_q - 1'b1;
        else if (tmo_fire) stale_d = stale_q + 1'b1;
        if (lookup_fail) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_data_q <= '0;
            hdr_strb_q <= '0;
            hdr_last_q <= 1'b0;
            id_q       <= '0;
            tmo_q      <= '0;
            stale_q    <= '0;
            drop_q     <= '0;
        end else begin
            hdr_data_q <= hdr_data_d;
            hdr_strb_q <= hdr_strb_d;
            hdr_last_q <= hdr_last_d;
            id_q       <= id_d;
            tmo_q      <= tmo_d;
            stale_q    <= stale_d;
            drop_q     <= drop_d;
        end
    end
endmodule

// File: doc/rx_conn_filter.md
Name: rx_conn_filter

Overview:
- Ingress filter stage directly upstream of the connection manager's forward-lookup port.
- Takes 64-bit AXI-Stream packets whose first beat is the 64-bit connection key, issues one forward lookup per packet, and waits for hit/miss plus the 32-bit connection ID.
- On hit: forwards the whole packet with the ID on tuser. On miss or timeout: silently drops the packet.

Parameters:
- CNT_W, 32: width of the drop counter.
- TIMEOUT_CYCLES, 1024: max cycles in WAIT before the lookup is treated as a miss; 0 disables the timeout.
- STALE_W, 4: width of the stale-response counter.

Ports:
- clk  in  1  clock, shared with the connection manager
- rst  in  1  reset, asynchronous, active-high
- s_axis_tvalid  in  1  ingress beat valid
- s_axis_tready  out  1  ingress ready
- s_axis_tdata  in  64  ingress data; beat 0 = lookup key
- s_axis_tstrb  in  8  ingress byte strobes
- s_axis_tlast  in  1  ingress end of packet
- lkp_req_valid  out  1  lookup request valid (to fw_lookup_valid)
- lkp_req_ready  in  1  lookup request ready
- lkp_req_key  out  64  lookup key
- lkp_resp_valid  in  1  lookup response valid
- lkp_resp_ready  out  1  lookup response ready
- lkp_resp_hit  in  1  lookup hit
- lkp_resp_id  in  32  connection ID on hit
- m_axis_tvalid  out  1  egress valid
- m_axis_tready  in  1  egress ready
- m_axis_tdata  out  64  egress data
- m_axis_tstrb  out  8  egress strobes
- m_axis_tlast  out  1  egress end of packet
- m_axis_tuser  out  32  connection ID, constant over the packet
- drop_count  out  CNT_W  dropped-packet counter
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; all valid/ready outputs 0 except s_axis_tready=1 in IDLE; data/key/tuser registers 0; drop_count 0; stale counter 0.
- Reset mid-packet aborts the packet. Upstream must be reset together with this block.
- IDLE:
  - s_axis_tready=1.
  - On handshake, register the beat (data, strb, last) into the header register and the key; go to REQ.
- REQ:
  - lkp_req_valid=1, lkp_req_key=key (registered, stable while valid); s_axis_tready=0.
  - On lkp_req_ready, clear the timeout counter and go to WAIT.
- WAIT:
  - lkp_resp_ready=1; timeout counter increments each cycle.
  - If stale_cnt>0, a response decrements stale_cnt and is discarded; stay in WAIT.
  - Otherwise, on a response:
    - hit=1: latch lkp_resp_id into the ID register; go to FWD_HDR.
    - hit=0: drop_count++. If the header beat had last=1, go to IDLE; else go to DROP.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 with no usable response and stale_cnt < max:
    - stale_cnt++ and drop_count++; go to DROP or IDLE as for a miss.
    - If stale_cnt is at max, no timeout fires; keep waiting.
  - Response and timeout in the same cycle: the response wins.
- Any state: lkp_resp_ready=1 while stale_cnt>0; stale responses are always consumed and ignored.
- FWD_HDR:
  - m_axis_tvalid=1 with the header register and tuser=ID.
  - On m_axis_tready: go to IDLE if hdr last=1, else to FWD.
- FWD: combinational pass-through.
  - m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
  - tdata/tstrb/tlast come from s_axis; tuser=ID.
  - A handshake with tlast=1 returns to IDLE.
- DROP: s_axis_tready=1, m_axis_tvalid=0; a beat with tlast=1 returns to IDLE.
- Latency: with the lookup ready immediately and the response one cycle after the request handshake, the header beat is valid on egress in the 3rd cycle after ingress acceptance.
- Outstanding lookups: exactly one per packet; lkp_req_valid never asserts while in WAIT.
- m_axis_tvalid, once high, holds with stable data until the handshake; in FWD this relies on upstream AXIS compliance.
- drop_count wraps at 2^CNT_W.
- Single-beat packets are supported on both the hit and the miss path.

Optional Feature:
- Macro RX_CONN_FILTER_MISS_PASS_EN.
- Defined: on miss or timeout, the packet is forwarded (FWD_HDR/FWD) instead of dropped, with tuser=32'hFFFF_FFFF. drop_count still increments (it counts misses).
- Undefined: misses are dropped as specified above.

Test Plan:
- Hit path: 3-beat packet, key 64'h0A00_0001_1F90_0035; resp hit=1, id=32'h0000_0007 -> 3 beats out unchanged, tuser=7 on all beats, tlast on beat 3, drop_count=0.
- Miss path: 4-beat packet, resp hit=0 -> no egress beats; all 4 ingress beats accepted; drop_count=1; next packet processed normally.
- Backpressure: hold lkp_req_ready=0 for 5 cycles, then m_axis_tready toggling 1/0 -> key stable during the stall; egress data/tvalid stable while not ready; no beat lost or duplicated.
- Timeout: TIMEOUT_CYCLES=8, no response -> packet dropped at cycle 8 of WAIT, drop_count=1, stale_cnt=1. A late response arriving during the next packet is discarded; that packet's own hit response forwards it correctly.
- Single-beat hit and miss back-to-back -> hit beat forwarded with tlast=1; miss beat dropped; busy returns to 0 after each.
- Async reset asserted mid-FWD -> all valids drop to 0 immediately; drop_count=0; state IDLE with s_axis_tready=1 after release.
